// File: rtl/avalon_semaphore_bank_pkg.sv
// avalon_semaphore_bank_pkg: register map, flag layout and helpers
// shared by the semaphore bank top and its testbench-facing logic
package avalon_semaphore_bank_pkg;

    localparam int MAX_SEM = 8;

    localparam logic [3:0] SEM_BASE    = 4'h0;
    localparam logic [3:0] ADDR_INIT   = 4'h8;
    localparam logic [3:0] ADDR_FLAGS  = 4'h9;
    localparam logic [3:0] ADDR_IRQ_EN = 4'hA;

    localparam int OVF_LSB      = 0;
    localparam int FAIL_LSB     = 8;
    localparam int INIT_IDX_LSB = 16;

    // Clamp a count to one seven-segment digit.
    function automatic logic [3:0] sat_nib(input logic [15:0] v);
        return (v > 16'd15) ? 4'hF : v[3:0];
    endfunction

endpackage

// File: rtl/avalon_semaphore_bank_sem_counter.sv
// sem_counter: saturating up/down counter with parallel load
// load has priority; inc holds at max, dec holds at zero
module sem_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             inc,
    input  logic             dec,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic [CNT_W-1:0] count,
    output logic             zero,
    output logic             at_max
);

    assign zero   = (count == '0);
    assign at_max = &count;

    // Count register: load, then saturating V, then saturating P.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (inc && !at_max) begin
            count <= count + 1'b1;
        end else if (dec && !zero) begin
            count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/avalon_semaphore_bank.sv
// avalon_semaphore_bank: Avalon-MM bank of counting semaphores
// read = try-P, write = V; sticky flags, irq and a HEX export
module avalon_semaphore_bank
    import avalon_semaphore_bank_pkg::*;
#(
    parameter int NUM_SEM = 8,
    parameter int CNT_W   = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [3:0]  avs_address,
    input  logic        avs_read,
    input  logic        avs_write,
    input  logic [31:0] avs_writedata,
    output logic [31:0] avs_readdata,
    output logic        avs_readdatavalid,
    output logic        irq,
    output logic [31:0] coe_export
);

    logic               wr;
    logic               rd;
    logic               sem_hit;
    logic [2:0]         sidx;
    logic [2:0]         init_idx;
    logic               init_wr;
    logic               flags_wr;
    logic               irq_en_wr;
    logic [MAX_SEM-1:0] sel;
    logic [MAX_SEM-1:0] zero;
    logic [MAX_SEM-1:0] at_max;
    logic [MAX_SEM-1:0] nz_mask;
    logic [MAX_SEM-1:0] ovf_set;
    logic [MAX_SEM-1:0] fail_set;
    logic [MAX_SEM-1:0] ovf_clr;
    logic [MAX_SEM-1:0] fail_clr;
    logic [MAX_SEM-1:0] ovf;
    logic [MAX_SEM-1:0] fail;
    logic [15:0]        irq_en;
    logic [CNT_W-1:0]   cnt [MAX_SEM];
    logic [31:0]        rdata;
    logic [31:0]        export_next;
    logic               rdv_q;
    logic               unused_wdata;

    // A write in the same cycle as a read wins; the read is dropped.
    assign wr   = avs_write;
    assign rd   = avs_read & ~avs_write;
    assign sidx = avs_address[2:0];

    assign sem_hit = ((avs_address & 4'h8) == SEM_BASE)
                  && (int'(sidx) < NUM_SEM);

    assign sel = sem_hit ? (MAX_SEM'(1) << sidx) : '0;

    assign init_wr   = wr && (avs_address == ADDR_INIT);
    assign flags_wr  = wr && (avs_address == ADDR_FLAGS);
    assign irq_en_wr = wr && (avs_address == ADDR_IRQ_EN);
    assign init_idx  = avs_writedata[INIT_IDX_LSB +: 3];

    assign ovf_set  = sel & at_max & {MAX_SEM{wr}};
    assign fail_set = sel & zero & {MAX_SEM{rd}};
    assign ovf_clr  = flags_wr ? avs_writedata[OVF_LSB +: MAX_SEM] : '0;
    assign fail_clr = flags_wr ? avs_writedata[FAIL_LSB +: MAX_SEM] : '0;

    assign nz_mask      = ~zero;
    assign unused_wdata = ^avs_writedata[31:19];

    for (genvar i = 0; i < MAX_SEM; i++) begin : g_sem
        if (i < NUM_SEM) begin : g_on
            sem_counter #(
                .CNT_W(CNT_W)
            ) u_cnt (
                .clk     (clk),
                .reset_n (reset_n),
                .inc     (wr && sel[i]),
                .dec     (rd && sel[i]),
                .load    (init_wr && (init_idx == 3'(i))),
                .load_val(avs_writedata[CNT_W-1:0]),
                .count   (cnt[i]),
                .zero    (zero[i]),
                .at_max  (at_max[i])
            );
        end else begin : g_off
            assign cnt[i]    = '0;
            assign zero[i]   = 1'b1;
            assign at_max[i] = 1'b0;
        end
    end

    // Read mux: P result for semaphores, status for control regs.
    always_comb begin
        rdata = '0;
        unique case (1'b1)
            sem_hit:
                rdata = zero[sidx] ? '0
                      : (32'h8000_0000 | 32'(cnt[sidx]));
            (avs_address == ADDR_INIT):
                rdata = {24'b0, nz_mask};
            (avs_address == ADDR_FLAGS):
                rdata = {16'b0, fail, ovf};
            (avs_address == ADDR_IRQ_EN):
                rdata = {16'b0, irq_en};
            default:
                rdata = '0;
        endcase
    end

    // One clamped nibble per HEX digit.
    always_comb begin
        export_next = '0;
        for (int i = 0; i < MAX_SEM; i++) begin
            export_next[4*i +: 4] = sat_nib(16'(cnt[i]));
        end
    end

    // Read response pipeline, fixed latency of one cycle.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rdv_q        <= 1'b0;
            avs_readdata <= '0;
        end else begin
            rdv_q <= rd;
            if (rd) begin
                avs_readdata <= rdata;
            end
        end
    end

    // A response still in flight when reset arrives is suppressed.
    assign avs_readdatavalid = rdv_q & reset_n;

    // Sticky flags (set beats W1C), irq enable, irq and export.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ovf        <= '0;
            fail       <= '0;
            irq_en     <= '0;
            irq        <= 1'b0;
            coe_export <= '0;
        end else begin
            ovf  <= (ovf & ~ovf_clr) | ovf_set;
            fail <= (fail & ~fail_clr) | fail_set;
            if (irq_en_wr) begin
                irq_en <= avs_writedata[15:0];
            end
            irq        <= |({fail, ovf} & irq_en);
            coe_export <= export_next;
        end
    end

endmodule
